// File: rtl/sys_ctrl.sv
// Command controller between the UART receiver and the reg file / ALU / TX path.
// Byte frames (AA write, BB read, CC load-operands-and-run, DD run) become strobes; results return as bytes.
module sys_ctrl #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      rx_data_in,
    input  logic                  rx_valid_in,
    output logic [ADDR_WIDTH-1:0] rf_addr_out,
    output logic                  rf_wr_en_out,
    output logic [WIDTH-1:0]      rf_wr_data_out,
    output logic                  rf_rd_en_out,
    input  logic [WIDTH-1:0]      rf_rd_data_in,
    input  logic                  rf_rd_valid_in,
    output logic                  alu_en_out,
    output logic [FUN_WIDTH-1:0]  alu_fun_out,
    output logic                  alu_clk_en_out,
    input  logic [2*WIDTH-1:0]    alu_out_in,
    input  logic                  alu_valid_in,
    output logic [WIDTH-1:0]      tx_data_out,
    output logic                  tx_valid_out,
    input  logic                  tx_ready_in,
    output logic                  cmd_drop_out,
    output logic [3:0]            dbg_state_out
);

    localparam logic [WIDTH-1:0] CMD_WR  = WIDTH'(8'hAA);
    localparam logic [WIDTH-1:0] CMD_RD  = WIDTH'(8'hBB);
    localparam logic [WIDTH-1:0] CMD_OP  = WIDTH'(8'hCC);
    localparam logic [WIDTH-1:0] CMD_ALU = WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WR_ADDR  = 4'd1,
        WR_DATA  = 4'd2,
        RD_ADDR  = 4'd3,
        RD_WAIT  = 4'd4,
        OP_A     = 4'd5,
        OP_B     = 4'd6,
        ALU_FUN  = 4'd7,
        ALU_WAIT = 4'd8,
        TX_LO    = 4'd9,
        TX_HI    = 4'd10
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WIDTH-1:0]      alu_hi_q;

    assign dbg_state_out = state;

    // TX handshake: a byte transfers on any cycle where tx_valid_out and tx_ready_in are both high;
    // tx_valid_out/tx_data_out never change until that happens, and ready alone transfers nothing.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            addr_q         <= '0;
            alu_hi_q       <= '0;
            rf_addr_out    <= '0;
            rf_wr_en_out   <= 1'b0;
            rf_wr_data_out <= '0;
            rf_rd_en_out   <= 1'b0;
            alu_en_out     <= 1'b0;
            alu_fun_out    <= '0;
            alu_clk_en_out <= 1'b0;
            tx_data_out    <= '0;
            tx_valid_out   <= 1'b0;
            cmd_drop_out   <= 1'b0;
        end else begin
            rf_wr_en_out <= 1'b0;
            rf_rd_en_out <= 1'b0;
            alu_en_out   <= 1'b0;
            cmd_drop_out <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_valid_in) begin
                        case (rx_data_in)
                            CMD_WR:  state <= WR_ADDR;
                            CMD_RD:  state <= RD_ADDR;
                            CMD_OP:  state <= OP_A;
                            CMD_ALU: state <= ALU_FUN;
                            default: cmd_drop_out <= 1'b1;
                        endcase
                    end
                end

                WR_ADDR: begin
                    if (rx_valid_in) begin
                        addr_q <= rx_data_in[ADDR_WIDTH-1:0];
                        state  <= WR_DATA;
                    end
                end

                WR_DATA: begin
                    if (rx_valid_in) begin
                        rf_addr_out    <= addr_q;
                        rf_wr_data_out <= rx_data_in;
                        rf_wr_en_out   <= 1'b1;
                        state          <= IDLE;
                    end
                end

                RD_ADDR: begin
                    if (rx_valid_in) begin
                        rf_addr_out  <= rx_data_in[ADDR_WIDTH-1:0];
                        rf_rd_en_out <= 1'b1;
                        state        <= RD_WAIT;
                    end
                end

                RD_WAIT: begin
                    cmd_drop_out <= rx_valid_in;
                    if (rf_rd_valid_in) begin
                        tx_data_out  <= rf_rd_data_in;
                        tx_valid_out <= 1'b1;
                        state        <= TX_HI;
                    end
                end

                OP_A: begin
                    if (rx_valid_in) begin
                        rf_addr_out    <= '0;
                        rf_wr_data_out <= rx_data_in;
                        rf_wr_en_out   <= 1'b1;
                        state          <= OP_B;
                    end
                end

                OP_B: begin
                    if (rx_valid_in) begin
                        rf_addr_out    <= ADDR_WIDTH'(1);
                        rf_wr_data_out <= rx_data_in;
                        rf_wr_en_out   <= 1'b1;
                        state          <= ALU_FUN;
                    end
                end

                ALU_FUN: begin
                    if (rx_valid_in) begin
                        alu_fun_out    <= rx_data_in[FUN_WIDTH-1:0];
                        alu_en_out     <= 1'b1;
                        alu_clk_en_out <= 1'b1;
                        state          <= ALU_WAIT;
                    end
                end

                ALU_WAIT: begin
                    cmd_drop_out <= rx_valid_in;
                    // The ALU clock keeps running through the result cycle and is gated off right after.
                    if (alu_valid_in) begin
                        alu_clk_en_out <= 1'b0;
                        tx_data_out    <= alu_out_in[WIDTH-1:0];
                        alu_hi_q       <= alu_out_in[2*WIDTH-1:WIDTH];
                        tx_valid_out   <= 1'b1;
                        state          <= TX_LO;
                    end
                end

                TX_LO: begin
                    cmd_drop_out <= rx_valid_in;
                    if (tx_valid_out && tx_ready_in) begin
                        tx_data_out <= alu_hi_q;
                        state       <= TX_HI;
                    end
                end

                TX_HI: begin
                    cmd_drop_out <= rx_valid_in;
                    if (tx_valid_out && tx_ready_in) begin
                        tx_valid_out <= 1'b0;
                        state        <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed bench for sys_ctrl: write, read, operand+ALU, drop and mid-frame reset scenarios.
module tb_sys_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data_in;
    logic        rx_valid_in;
    logic [3:0]  rf_addr_out;
    logic        rf_wr_en_out;
    logic [7:0]  rf_wr_data_out;
    logic        rf_rd_en_out;
    logic [7:0]  rf_rd_data_in;
    logic        rf_rd_valid_in;
    logic        alu_en_out;
    logic [3:0]  alu_fun_out;
    logic        alu_clk_en_out;
    logic [15:0] alu_out_in;
    logic        alu_valid_in;
    logic [7:0]  tx_data_out;
    logic        tx_valid_out;
    logic        tx_ready_in;
    logic        cmd_drop_out;
    logic [3:0]  dbg_state_out;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt, rd_cnt, alu_cnt, drop_cnt;
    logic [7:0] exp_q[$];

    sys_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rx_data_in     (rx_data_in),
        .rx_valid_in    (rx_valid_in),
        .rf_addr_out    (rf_addr_out),
        .rf_wr_en_out   (rf_wr_en_out),
        .rf_wr_data_out (rf_wr_data_out),
        .rf_rd_en_out   (rf_rd_en_out),
        .rf_rd_data_in  (rf_rd_data_in),
        .rf_rd_valid_in (rf_rd_valid_in),
        .alu_en_out     (alu_en_out),
        .alu_fun_out    (alu_fun_out),
        .alu_clk_en_out (alu_clk_en_out),
        .alu_out_in     (alu_out_in),
        .alu_valid_in   (alu_valid_in),
        .tx_data_out    (tx_data_out),
        .tx_valid_out   (tx_valid_out),
        .tx_ready_in    (tx_ready_in),
        .cmd_drop_out   (cmd_drop_out),
        .dbg_state_out  (dbg_state_out)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // strobe counters sample the pre-edge (settled) output values
    always @(posedge clk) begin
        if (reset_n) begin
            if (rf_wr_en_out) wr_cnt++;
            if (rf_rd_en_out) rd_cnt++;
            if (alu_en_out)   alu_cnt++;
            if (cmd_drop_out) drop_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks: inputs change on the falling edge
    task automatic clear_counts();
        wr_cnt = 0; rd_cnt = 0; alu_cnt = 0; drop_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data_in  = b;
        rx_valid_in = 1'b1;
        @(negedge clk);
        rx_valid_in = 1'b0;
        rx_data_in  = 8'h00;
    endtask

    task automatic take_byte(input int stall);
        int budget;
        logic [7:0] held;
        logic [7:0] exp;
        budget = 50;
        while (!tx_valid_out && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("tx_valid_wait", 32'(tx_valid_out), 32'd1);
        held = tx_data_out;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("tx_data_hold", 32'(tx_data_out), 32'(held));
            check("tx_valid_hold", 32'(tx_valid_out), 32'd1);
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check("tx_data", 32'(held), 32'(exp));
        tx_ready_in = 1'b1;
        @(negedge clk);
        tx_ready_in = 1'b0;
    endtask

    task automatic alu_result(input logic [15:0] r);
        @(negedge clk);
        check("alu_clk_en_in_wait", 32'(alu_clk_en_out), 32'd1);
        alu_out_in   = r;
        alu_valid_in = 1'b1;
        @(negedge clk);
        alu_valid_in = 1'b0;
        check("alu_clk_en_after_valid", 32'(alu_clk_en_out), 32'd0);
        check("tx_valid_after_alu", 32'(tx_valid_out), 32'd1);
    endtask

    initial begin
        reset_n        = 1'b0;
        rx_data_in     = 8'hAA;
        rx_valid_in    = 1'b1;
        rf_rd_data_in  = 8'hFF;
        rf_rd_valid_in = 1'b1;
        alu_out_in     = 16'hFFFF;
        alu_valid_in   = 1'b1;
        tx_ready_in    = 1'b1;
        clear_counts();

        // reset with arbitrary inputs
        repeat (2) @(negedge clk);
        check("rst_outputs", {rf_addr_out, rf_wr_en_out, rf_wr_data_out, rf_rd_en_out, alu_en_out,
                              alu_fun_out, alu_clk_en_out, tx_data_out, tx_valid_out, cmd_drop_out}, 32'd0);
        check("rst_state", 32'(dbg_state_out), 32'd0);
        rx_valid_in = 1'b0; rx_data_in = 8'h00; rf_rd_valid_in = 1'b0;
        alu_valid_in = 1'b0; alu_out_in = 16'h0; tx_ready_in = 1'b0; rf_rd_data_in = 8'h00;
        reset_n = 1'b1;
        clear_counts();
        repeat (3) @(negedge clk);
        check("idle_state", 32'(dbg_state_out), 32'd0);
        check("idle_no_strobes", 32'(wr_cnt + rd_cnt + alu_cnt + drop_cnt), 32'd0);

        // register write
        send_byte(8'hAA);
        send_byte(8'h05);
        check("wr_no_early_strobe", 32'(rf_wr_en_out), 32'd0);
        send_byte(8'h3C);
        check("wr_en", 32'(rf_wr_en_out), 32'd1);
        check("wr_addr", 32'(rf_addr_out), 32'h5);
        check("wr_data", 32'(rf_wr_data_out), 32'h3C);
        repeat (2) @(negedge clk);
        check("wr_single_pulse", 32'(wr_cnt), 32'd1);
        check("wr_no_tx", 32'(tx_valid_out), 32'd0);
        check("wr_data_held", 32'(rf_wr_data_out), 32'h3C);

        // register read with back-pressure
        clear_counts();
        send_byte(8'hBB);
        send_byte(8'h07);
        check("rd_en", 32'(rf_rd_en_out), 32'd1);
        check("rd_addr", 32'(rf_addr_out), 32'h7);
        check("rd_wait_state", 32'(dbg_state_out), 32'd4);
        @(negedge clk);
        rf_rd_data_in  = 8'h5A;
        rf_rd_valid_in = 1'b1;
        @(negedge clk);
        rf_rd_valid_in = 1'b0;
        rf_rd_data_in  = 8'h00;
        exp_q.push_back(8'h5A);
        take_byte(3);
        check("rd_tx_done", 32'(tx_valid_out), 32'd0);
        check("rd_back_idle", 32'(dbg_state_out), 32'd0);
        check("rd_single_pulse", 32'(rd_cnt), 32'd1);

        // operands + ALU
        clear_counts();
        send_byte(8'hCC);
        check("op_a_state", 32'(dbg_state_out), 32'd5);
        send_byte(8'h12);
        check("op_a_wr", {rf_wr_en_out, rf_addr_out, rf_wr_data_out}, {19'd0, 1'b1, 4'h0, 8'h12});
        send_byte(8'h34);
        check("op_b_wr", {rf_wr_en_out, rf_addr_out, rf_wr_data_out}, {19'd0, 1'b1, 4'h1, 8'h34});
        send_byte(8'h02);
        check("alu_start", {alu_en_out, alu_clk_en_out, alu_fun_out}, {26'd0, 1'b1, 1'b1, 4'h2});
        check("alu_wait_state", 32'(dbg_state_out), 32'd8);
        alu_result(16'hABCD);
        exp_q.push_back(8'hCD);
        exp_q.push_back(8'hAB);
        take_byte(0);
        take_byte(2);
        check("alu_tx_done", 32'(tx_valid_out), 32'd0);
        check("alu_back_idle", 32'(dbg_state_out), 32'd0);
        check("alu_pulses", 32'(alu_cnt), 32'd1);
        check("alu_fun_held", 32'(alu_fun_out), 32'h2);

        // dropped bytes
        clear_counts();
        send_byte(8'h55);
        check("drop_idle", 32'(cmd_drop_out), 32'd1);
        check("drop_idle_state", 32'(dbg_state_out), 32'd0);
        send_byte(8'hDD);
        send_byte(8'h13);
        check("dd_fun", 32'(alu_fun_out), 32'h3);
        send_byte(8'h99);
        check("drop_alu_wait", 32'(cmd_drop_out), 32'd1);
        check("drop_keeps_wait", 32'(dbg_state_out), 32'd8);
        alu_result(16'h1234);
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h12);
        take_byte(1);
        take_byte(0);
        repeat (2) @(negedge clk);
        check("drop_count", 32'(drop_cnt), 32'd2);
        check("drop_no_rf_strobes", 32'(wr_cnt + rd_cnt), 32'd0);
        check("drop_alu_pulses", 32'(alu_cnt), 32'd1);

        // reset in the middle of a write frame
        clear_counts();
        send_byte(8'hAA);
        send_byte(8'h03);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("midrst_state", 32'(dbg_state_out), 32'd0);
        check("midrst_addr", 32'(rf_addr_out), 32'd0);
        send_byte(8'h77);
        check("midrst_drop", 32'(cmd_drop_out), 32'd1);
        check("midrst_no_wr", 32'(rf_wr_en_out), 32'd0);
        repeat (2) @(negedge clk);
        check("midrst_wr_count", 32'(wr_cnt), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sys_ctrl.md
Name: sys_ctrl

Overview:
- Command controller directly downstream of the UART receiver, in the reference (system) clock domain.
- Parses received byte frames into register-file writes and reads and into ALU operations.
- Returns read data and ALU results as a byte stream toward the UART transmitter path via a valid/ready handshake.
- Reg file, ALU and TX-side buffering are separate blocks.

Parameters:
- WIDTH, 8, byte / register data width.
- ADDR_WIDTH, 4, register-file address width.
- FUN_WIDTH, 4, ALU function code width; taken from the low bits of the function byte.

Ports:
- clk  input  1  controller clock
- reset_n  input  1  synchronous active-low reset
- rx_data_in  input  WIDTH  received byte
- rx_valid_in  input  1  single-cycle pulse per received byte
- rf_addr_out  output  ADDR_WIDTH  register-file address
- rf_wr_en_out  output  1  register-file write strobe, one cycle
- rf_wr_data_out  output  WIDTH  register-file write data
- rf_rd_en_out  output  1  register-file read strobe, one cycle
- rf_rd_data_in  input  WIDTH  register-file read data
- rf_rd_valid_in  input  1  read data valid pulse
- alu_en_out  output  1  ALU start strobe, one cycle
- alu_fun_out  output  FUN_WIDTH  ALU function code
- alu_clk_en_out  output  1  ALU clock-gate enable
- alu_out_in  input  2*WIDTH  ALU result
- alu_valid_in  input  1  ALU result valid pulse
- tx_data_out  output  WIDTH  byte to transmit
- tx_valid_out  output  1  tx byte valid
- tx_ready_in  input  1  downstream can accept a byte
- cmd_drop_out  output  1  one-cycle pulse when a received byte is discarded

Behaviour:
- Reset: reset_n low at a clk edge forces state IDLE and all outputs to 0 at that edge. This applies mid-frame too: a partial frame is abandoned, no strobe is issued, and any pending tx byte is dropped.
- All outputs are registered. A strobe is issued in the cycle after the rx_valid_in that completes the field.
- Frame formats (bytes in arrival order):
  - 0xAA ADDR DATA: register write.
  - 0xBB ADDR: register read; returns 1 byte.
  - 0xCC A B FUN: write A to address 0 and B to address 1, then run the ALU; returns 2 bytes.
  - 0xDD FUN: run the ALU on the current operands; returns 2 bytes.
- Address bytes use the low ADDR_WIDTH bits. FUN bytes use the low FUN_WIDTH bits.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI.
- IDLE:
  - AA -> WR_ADDR; BB -> RD_ADDR; CC -> OP_A; DD -> ALU_FUN.
  - Any other byte: stay in IDLE and pulse cmd_drop_out.
- WR_ADDR: latch address -> WR_DATA.
- WR_DATA: on a byte, pulse rf_wr_en_out with the latched address and the byte -> IDLE.
- RD_ADDR: on a byte, pulse rf_rd_en_out with that address -> RD_WAIT.
- RD_WAIT: on rf_rd_valid_in, load rf_rd_data_in into tx_data_out and assert tx_valid_out -> TX_HI. In this case TX_HI carries the only byte.
- OP_A: on a byte, write it to address 0 -> OP_B.
- OP_B: on a byte, write it to address 1 -> ALU_FUN.
- ALU_FUN: on a byte:
  - Pulse alu_en_out with alu_fun_out = FUN.
  - Raise alu_clk_en_out in the same cycle and hold it until the cycle after alu_valid_in.
  - -> ALU_WAIT.
- ALU_WAIT: on alu_valid_in, capture alu_out_in; tx_data_out = bits [WIDTH-1:0], tx_valid_out = 1 -> TX_LO.
- TX_LO: on tx_valid_out && tx_ready_in, load bits [2*WIDTH-1:WIDTH] and keep valid -> TX_HI.
- TX_HI: on tx_valid_out && tx_ready_in, deassert tx_valid_out -> IDLE.
- Handshake: tx_valid_out and tx_data_out hold stable until accepted. A transfer occurs on any cycle with valid and ready both high; ready alone transfers nothing.
- Bytes received in RD_WAIT, ALU_WAIT, TX_LO or TX_HI are discarded and each pulses cmd_drop_out.
- Address, data and function are always registered from rx_data_in when that field's rx_valid_in is seen.
- alu_fun_out and rf_addr_out hold their last values between strobes.
- rf_wr_data_out holds its last value between strobes.
- No timeouts: wait states persist until the valid or ready input arrives.

Test Plan:
- Reset: hold reset_n=0 for 2 clk with arbitrary inputs -> all outputs 0; after release, state IDLE and no strobes.
- Write: bytes AA,05,3C -> single rf_wr_en_out pulse with rf_addr_out=5, rf_wr_data_out=0x3C; tx_valid_out stays 0.
- Read: BB,07, then rf_rd_valid_in with data 0x5A; tx_ready_in low 3 cycles then high -> rf_rd_en_out pulse with addr 7; tx_data_out=0x5A held 3 cycles; one transfer, then IDLE.
- ALU with operands: CC,12,34,02, then alu_valid_in with 0xABCD:
  - Writes 0x12 to addr 0 and 0x34 to addr 1.
  - alu_en_out pulse with fun=2; alu_clk_en_out high until the cycle after valid.
  - tx sends CD then AB.
- Drops: byte 0x55 in IDLE, then a byte during ALU_WAIT -> two cmd_drop_out pulses; no strobes issued; ALU frame completes normally.
- Reset mid-frame: AA,03, then reset_n low 1 cycle, then 0x77 -> no rf_wr_en_out; 0x77 dropped as an unknown command.
